// File: rtl/mem_stage_v2.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response,
// buffers the returned word and formats the load result for WB and ID forwarding.
module mem_stage_v2 #(
    parameter  int DW  = 32,
    parameter  int RAW = 5,
    localparam int ESW = 5 + RAW + 2 * DW,
    localparam int WSW = 1 + RAW + 2 * DW,
    localparam int DSW = 3 + RAW + DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ws_allowin,
    output logic           ms_allowin,
    input  logic           es_to_ms_valid,
    input  logic [ESW-1:0] es_to_ms_bus,
    output logic           ms_to_ws_valid,
    output logic [WSW-1:0] ms_to_ws_bus,
    output logic [DSW-1:0] ms_to_ds_bus,
    input  logic           ms_flush,
    input  logic           data_sram_data_ok,
    input  logic [DW-1:0]  data_sram_rdata
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_DONE,
        S_DISCARD
    } state_e;

    state_e         state_q;
    logic [ESW-1:0] bus_q;
    logic [DW-1:0]  rdata_q;

    // Fields of the latched EX payload.
    logic [2:0]     ld_op;
    logic           req_issued;
    logic           gr_we;
    logic [RAW-1:0] dest;
    logic [DW-1:0]  alu_result;
    logic [DW-1:0]  pc;

    assign {ld_op, req_issued, gr_we, dest, alu_result, pc} = bus_q;

    logic ms_valid;
    logic ms_pending;
    logic accept;

    assign ms_valid   = (state_q == S_WAIT) || (state_q == S_DONE);
    assign ms_pending = (state_q == S_WAIT);
    assign ms_allowin = (state_q == S_EMPTY) || ((state_q == S_DONE) && ws_allowin);
    // A flush cycle never takes a new instruction, even when allowin is high.
    assign accept     = es_to_ms_valid && ms_allowin && !ms_flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_EMPTY, S_DONE: begin
                    if (ms_flush) begin
                        state_q <= S_EMPTY;
                    end else if (accept) begin
                        bus_q   <= es_to_ms_bus;
                        state_q <= es_to_ms_bus[ESW-4] ? S_WAIT : S_DONE;
                    end else if ((state_q == S_DONE) && !ws_allowin) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_EMPTY;
                    end
                end
                S_WAIT: begin
                    if (ms_flush) begin
                        state_q <= data_sram_data_ok ? S_EMPTY : S_DISCARD;
                    end else if (data_sram_data_ok) begin
                        rdata_q <= data_sram_rdata;
                        state_q <= S_DONE;
                    end
                end
                S_DISCARD: begin
                    if (data_sram_data_ok) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] final_result;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        ld_byte      = rdata_q[7:0];
        ld_half      = rdata_q[15:0];
        final_result = alu_result;
        case (alu_result[1:0])
            2'b00:   ld_byte = rdata_q[7:0];
            2'b01:   ld_byte = rdata_q[15:8];
            2'b10:   ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        if (alu_result[1]) begin
            ld_half = rdata_q[31:16];
        end
        case (ld_op)
            3'b000:  final_result = alu_result;
            3'b001:  final_result = {{(DW-8){ld_byte[7]}}, ld_byte};
            3'b010:  final_result = {{(DW-8){1'b0}}, ld_byte};
            3'b011:  final_result = {{(DW-16){ld_half[15]}}, ld_half};
            3'b100:  final_result = {{(DW-16){1'b0}}, ld_half};
            default: final_result = rdata_q;
        endcase
    end

    assign ms_to_ws_valid = (state_q == S_DONE) && !ms_flush;
    assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_to_ds_bus   = {ms_valid, ms_pending, gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage_v2.sv
// Directed bench for mem_stage_v2: expected WB payloads are queued at issue time
// and a monitor pops and compares them on every WB transfer.
module tb_mem_stage_v2;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int ESW = 5 + RAW + 2 * DW;
    localparam int WSW = 1 + RAW + 2 * DW;
    localparam int DSW = 3 + RAW + DW;

    logic           clk = 1'b0;
    logic           reset;
    logic           ws_allowin;
    logic           ms_allowin;
    logic           es_to_ms_valid;
    logic [ESW-1:0] es_to_ms_bus;
    logic           ms_to_ws_valid;
    logic [WSW-1:0] ms_to_ws_bus;
    logic [DSW-1:0] ms_to_ds_bus;
    logic           ms_flush;
    logic           data_sram_data_ok;
    logic [DW-1:0]  data_sram_rdata;

    int total = 0;
    int bad   = 0;

    logic [WSW-1:0] exp_q[$];

    mem_stage_v2 #(.DW(DW), .RAW(RAW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .ms_flush          (ms_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [ESW-1:0] mk_es(input logic [2:0] ld, input logic req, input logic we,
                                             input logic [RAW-1:0] dst, input logic [DW-1:0] alu,
                                             input logic [DW-1:0] pc);
        return {ld, req, we, dst, alu, pc};
    endfunction

    function automatic logic [WSW-1:0] mk_ws(input logic we, input logic [RAW-1:0] dst,
                                             input logic [DW-1:0] res, input logic [DW-1:0] pc);
        return {we, dst, res, pc};
    endfunction

    // Advance one clock; single-cycle pulses drop back to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        ms_flush          = 1'b0;
    endtask

    // Monitor: every WB handshake must match the oldest queued expectation.
    initial begin
        logic [WSW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && ms_to_ws_valid && ws_allowin) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got %0h expected no transfer", ms_to_ws_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("ws_bus", ms_to_ws_bus, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Load/store vectors: ld_op, addr, returned word, expected final_result.
    logic [2:0]  t_ld  [7] = '{3'b100, 3'b011, 3'b010, 3'b001, 3'b101, 3'b111, 3'b000};
    logic [31:0] t_alu [7] = '{32'h2002, 32'h2000, 32'h2001, 32'h2000, 32'h2002, 32'h2001, 32'hCAFE_0000};
    logic [31:0] t_rd  [7] = '{32'h8001_0000, 32'h1234_9ABC, 32'h80AA_BBCC, 32'h80AA_BB7C,
                               32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h5555_5555};
    logic [31:0] t_exp [7] = '{32'h0000_8001, 32'hFFFF_9ABC, 32'h0000_00BB, 32'h0000_007C,
                               32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0000};

    initial begin
        logic [WSW-1:0] bp_exp;
        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ms_flush          = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_allowin", ms_allowin, 1);
        check("rst_ws_valid", ms_to_ws_valid, 0);
        check("rst_ds_bus", ms_to_ds_bus, 0);

        // ALU op: valid one cycle after accept
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h100);
        exp_q.push_back(mk_ws(1'b1, 5'd3, 32'h1234_5678, 32'h100));
        #1 check("alu_allowin", ms_allowin, 1);
        cyc();
        #1 check("alu_ws_valid", ms_to_ws_valid, 1);
        check("alu_ds_bus", ms_to_ds_bus, {1'b1, 1'b0, 1'b1, 5'd3, 32'h1234_5678});
        cyc();
        #1 check("alu_empty_allowin", ms_allowin, 1);
        check("alu_empty_valid", ms_to_ws_valid, 0);

        // LB from byte lane 3, response on the third wait cycle
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b001, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h104);
        exp_q.push_back(mk_ws(1'b1, 5'd5, 32'hFFFF_FF80, 32'h104));
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = 32'h80AA_BBCC;
            end
            #1 check("lb_wait_allowin", ms_allowin, 0);
            check("lb_wait_pending", ms_to_ds_bus[DSW-2], 1);
        end
        cyc();
        data_sram_rdata = 32'h1111_1111;
        #1 check("lb_ws_valid", ms_to_ws_valid, 1);
        cyc();
        #1 check("lb_empty_allowin", ms_allowin, 1);

        // Table of load/store formats, one-cycle response latency
        for (int k = 0; k < 7; k++) begin
            cyc();
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_es(t_ld[k], 1'b1, 1'b1, 5'(k + 8), t_alu[k], 32'h200 + 32'(k * 4));
            exp_q.push_back(mk_ws(1'b1, 5'(k + 8), t_exp[k], 32'h200 + 32'(k * 4)));
            cyc();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = t_rd[k];
            #1 check("tbl_pending", ms_to_ds_bus[DSW-2], 1);
            cyc();
            data_sram_rdata = 32'h0;
            #1 check("tbl_ws_valid", ms_to_ws_valid, 1);
        end

        // Back-pressure: DONE held 4 cycles with rdata and data_ok wiggling
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b101, 1'b1, 1'b1, 5'd9, 32'h3000, 32'h300);
        bp_exp         = mk_ws(1'b1, 5'd9, 32'hA5A5_0001, 32'h300);
        exp_q.push_back(bp_exp);
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hA5A5_0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            ws_allowin        = 1'b0;
            data_sram_data_ok = i[0];
            data_sram_rdata   = 32'h7700_0000 + 32'(i);
            #1 check("bp_valid", ms_to_ws_valid, 1);
            check("bp_bus_stable", ms_to_ws_bus, bp_exp);
            check("bp_allowin", ms_allowin, 0);
        end
        cyc();
        ws_allowin = 1'b1;
        #1 check("bp_release_valid", ms_to_ws_valid, 1);
        cyc();
        #1 check("bp_after_valid", ms_to_ws_valid, 0);
        check("bp_after_allowin", ms_allowin, 1);

        // Flush in WAIT, response two cycles later is dropped
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b101, 1'b1, 1'b1, 5'd10, 32'h4000, 32'h400);
        cyc();
        ms_flush = 1'b1;
        #1 check("fw_allowin0", ms_allowin, 0);
        check("fw_ws_valid0", ms_to_ws_valid, 0);
        cyc();
        #1 check("fw_allowin1", ms_allowin, 0);
        check("fw_ms_valid", ms_to_ds_bus[DSW-1], 0);
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        #1 check("fw_allowin2", ms_allowin, 0);
        cyc();
        #1 check("fw_empty_allowin", ms_allowin, 1);
        check("fw_empty_valid", ms_to_ws_valid, 0);

        // Flush and data_ok together in WAIT go straight to EMPTY
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b101, 1'b1, 1'b1, 5'd11, 32'h4004, 32'h404);
        cyc();
        ms_flush          = 1'b1;
        data_sram_data_ok = 1'b1;
        cyc();
        #1 check("fwd_allowin", ms_allowin, 1);
        check("fwd_ms_valid", ms_to_ds_bus[DSW-1], 0);

        // Flush in DONE masks the transfer and refuses the offered instruction
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b1, 5'd12, 32'h55, 32'h500);
        cyc();
        ms_flush       = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b1, 5'd13, 32'h66, 32'h999);
        #1 check("fd_ws_valid", ms_to_ws_valid, 0);
        cyc();
        #1 check("fd_allowin", ms_allowin, 1);
        check("fd_not_accepted", ms_to_ws_valid, 0);

        // Back-to-back accept from DONE
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b1, 5'd14, 32'h11, 32'h600);
        exp_q.push_back(mk_ws(1'b1, 5'd14, 32'h11, 32'h600));
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b0, 5'd15, 32'h22, 32'h604);
        exp_q.push_back(mk_ws(1'b0, 5'd15, 32'h22, 32'h604));
        #1 check("b2b_allowin", ms_allowin, 1);
        cyc();
        #1 check("b2b_valid", ms_to_ws_valid, 1);
        cyc();
        #1 check("b2b_empty", ms_allowin, 1);

        // Reset in WAIT; the stale response afterwards is ignored
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b101, 1'b1, 1'b1, 5'd16, 32'h7000, 32'h700);
        cyc();
        reset = 1'b1;
        #1 check("rw_pending", ms_to_ds_bus[DSW-2], 1);
        cyc();
        reset = 1'b0;
        #1 check("rw_ms_valid", ms_to_ds_bus[DSW-1], 0);
        check("rw_allowin", ms_allowin, 1);
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_0000;
        cyc();
        #1 check("rw_stale_valid", ms_to_ws_valid, 0);
        check("rw_stale_allowin", ms_allowin, 1);

        repeat (3) cyc();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_v2.md
MEM_STAGE_V2 -- requirements
Module: mem_stage_v2

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data and PC width; only DW=32 is required.
REQ-002 SHALL have parameter RAW, default 5, meaning register-address width.
REQ-003 SHALL have derived width ESW = 5+RAW+2*DW, where es_to_ms_bus = {ld_op[2:0], req_issued, gr_we, dest[RAW-1:0], alu_result[DW-1:0], pc[DW-1:0]}, MSB first.
REQ-004 SHALL have derived width WSW = 1+RAW+2*DW, where ms_to_ws_bus = {gr_we, dest, final_result, pc}.
REQ-005 SHALL have derived width DSW = 3+RAW+DW, where ms_to_ds_bus = {ms_valid, ms_pending, gr_we, dest, final_result}.
REQ-006 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port ws_allowin, input, 1, WB stage can accept.
REQ-009 SHALL have port ms_allowin, output, 1, MEM stage can accept.
REQ-010 SHALL have port es_to_ms_valid, input, 1, EX stage holds a valid instruction.
REQ-011 SHALL have port es_to_ms_bus, input, ESW, EX payload.
REQ-012 SHALL have port ms_to_ws_valid, output, 1, MEM result valid to WB.
REQ-013 SHALL have port ms_to_ws_bus, output, WSW, WB payload.
REQ-014 SHALL have port ms_to_ds_bus, output, DSW, forwarding and stall info to ID.
REQ-015 SHALL have port ms_flush, input, 1, squash the instruction held in MEM.
REQ-016 SHALL have port data_sram_data_ok, input, 1, one-cycle pulse marking read data or write ack returned.
REQ-017 SHALL have port data_sram_rdata, input, DW, read data, valid only when data_ok=1.

Function
REQ-018 SHALL implement states EMPTY, WAIT, DONE and DISCARD; ms_valid SHALL be 1 in WAIT and DONE only.
REQ-019 SHALL assert ms_allowin = (EMPTY) or (DONE and ws_allowin); in WAIT and DISCARD, ms_allowin SHALL be 0.
REQ-020 SHALL latch es_to_ms_bus when es_to_ms_valid and ms_allowin; a different cycle SHALL not change the latch.
REQ-021 SHALL enter WAIT on accept with req_issued=1, and SHALL enter DONE on accept with req_issued=0.
REQ-022 SHALL go from EMPTY or DONE to EMPTY when no instruction is accepted and DONE is not retained.
REQ-023 SHALL go from WAIT to DONE on data_ok, capturing rdata into an internal buffer in the same edge; rdata SHALL not be used after that cycle.
REQ-024 SHALL stay in DONE while ws_allowin=0, holding ms_to_ws_bus constant.
REQ-025 SHALL drive ms_to_ws_valid = (state==DONE) and not ms_flush; minimum latency accept-to-valid SHALL be 1 cycle.
REQ-026 SHALL select the load result by ld_op: 000 alu_result; 001 LB sign-extended; 010 LBU zero-extended; 011 LH sign-extended; 100 LHU zero-extended; 101/110/111 LW; selection is combinational from the buffered word.
REQ-027 SHALL select the byte lane alu_result[1:0] for LB/LBU, the halfword alu_result[1] for LH/LHU, and SHALL ignore alu_result[1:0] for LW.
REQ-028 SHALL treat a store (req_issued=1, ld_op=000) as WAIT until data_ok, and SHALL then use final_result=alu_result.
REQ-029 SHALL drive ms_pending=1 in WAIT; ID SHALL treat ms_pending with a matching dest as a stall condition.
REQ-030 SHALL on ms_flush go WAIT->DISCARD, DONE->EMPTY and EMPTY->EMPTY, and SHALL not accept a new instruction that cycle.
REQ-031 SHALL in DISCARD drop the next data_ok and then go to EMPTY; WAIT with flush and data_ok in the same cycle SHALL go to EMPTY.
REQ-032 SHALL not support more than one outstanding request; data_ok in EMPTY or DONE SHALL be ignored.

Reset
REQ-033 SHALL on reset enter EMPTY and clear ms_valid, ms_to_ws_valid, ms_pending and the data buffer to 0.
REQ-034 SHALL let reset override flush, data_ok and accept; a response pending at reset SHALL be ignored after reset.

Verification
REQ-035 SHALL pass an ALU op check: accept ld_op=000, req_issued=0, alu_result=0x1234_5678, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234_5678.
REQ-036 SHALL pass an LB check: ld_op=001, addr[1:0]=2'b11, data_ok after 3 cycles with rdata=0x80AA_BBCC -> result 0xFFFF_FF80, and ms_allowin=0 for the 3 wait cycles.
REQ-037 SHALL pass an LHU check: ld_op=100, addr[1]=1, rdata=0x8001_0000 -> result 0x0000_8001.
REQ-038 SHALL pass a back-pressure check: DONE with ws_allowin=0 for 4 cycles and rdata changing -> ms_to_ws_bus stable, one transfer when ws_allowin rises.
REQ-039 SHALL pass a flush-in-WAIT check: ms_flush in WAIT, data_ok 2 cycles later -> no ms_to_ws_valid, ms_allowin=0 until after data_ok, then EMPTY.
REQ-040 SHALL pass a reset-mid-WAIT check: reset in WAIT -> ms_valid=0 and ms_allowin=1 the next cycle.
